pal_cfg_loader: RTL

//  Upstream feeder for the PAL fabric's serial configuration chain. It accepts config bytes over a

---
 rtl/pal_cfg_loader_if.sv | 24 ++
 rtl/pal_cfg_loader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pal_cfg_loader_if.sv
// Signal bundle between a config-byte source and pal_cfg_loader.
// master = source/host side, slave = loader side.
interface pal_cfg_loader_if;
   logic       start;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       cfg_bit;
   logic       cfg_shift;
   logic       pal_en;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output start, din, din_valid,
      input  din_ready, cfg_bit, cfg_shift, pal_en, busy, done, err
   );

   modport slave (
      input  start, din, din_valid,
      output din_ready, cfg_bit, cfg_shift, pal_en, busy, done, err
   );
endinterface

// File: rtl/pal_cfg_loader.sv
// Serialises config bytes MSB-first onto the PAL configuration chain and
// validates a trailing XOR-8 checksum before enabling the PAL.
module pal_cfg_loader #(
   parameter int CFG_BITS = 396
) (
   input  logic            clk,
   input  logic            res_n,
   pal_cfg_loader_if.slave bus
);
   localparam int              NBYTES   = (CFG_BITS + 7) / 8;
   localparam int              BCW      = $clog2(NBYTES + 1);
   localparam logic [BCW-1:0]  NBYTES_C = BCW'(NBYTES);
   localparam logic [BCW-1:0]  LAST_IDX = BCW'(NBYTES - 1);
   localparam logic [3:0]      LAST_K   = 4'(CFG_BITS - 8 * (NBYTES - 1));

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_e;

   function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   state_e         state_q,     state_d;
   logic [BCW-1:0] byte_cnt_q,  byte_cnt_d;
   logic [3:0]     bit_cnt_q,   bit_cnt_d;
   logic [7:0]     sh_q,        sh_d;
   logic [7:0]     csum_q,      csum_d;
   logic [7:0]     chk_q,       chk_d;
   logic           cfg_bit_q,   cfg_bit_d;
   logic           cfg_shift_q, cfg_shift_d;
   logic           pal_en_q,    pal_en_d;
   logic           busy_q,      busy_d;
   logic           done_q,      done_d;
   logic           err_q,       err_d;

   logic           din_ready_s;
   logic           accept_s;
   logic           data_phase_s;

   // Next-state, shifter and status logic; start overrides everything but reset.
   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      csum_d       = csum_q;
      chk_d        = chk_q;
      pal_en_d     = pal_en_q;
      err_d        = err_q;
      done_d       = 1'b0;
      din_ready_s  = 1'b0;
      accept_s     = 1'b0;
      data_phase_s = (byte_cnt_q < NBYTES_C);

      // bit_cnt holds the number of bits still to present, including the current one
      if (bit_cnt_q != 4'd0) begin
         sh_d      = {sh_q[6:0], 1'b0};
         bit_cnt_d = bit_cnt_q - 4'd1;
      end else begin
         sh_d      = sh_q;
         bit_cnt_d = bit_cnt_q;
      end

      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
         end
         S_LOAD: begin
            if (data_phase_s) begin
               din_ready_s = (bit_cnt_q <= 4'd1) && !bus.start;
            end else begin
               din_ready_s = (bit_cnt_q == 4'd0) && !bus.start;
            end
            accept_s = bus.din_valid && din_ready_s;
            if (accept_s && data_phase_s) begin
               sh_d       = bus.din;
               bit_cnt_d  = (byte_cnt_q == LAST_IDX) ? LAST_K : 4'd8;
               csum_d     = csum_next(csum_q, bus.din);
               byte_cnt_d = byte_cnt_q + BCW'(1);
            end else if (accept_s) begin
               chk_d   = bus.din;
               state_d = S_CHECK;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_CHECK: begin
            if (csum_q == chk_q) begin
               state_d  = S_DONE;
               pal_en_d = 1'b1;
               done_d   = 1'b1;
            end else begin
               state_d  = S_ERR;
               pal_en_d = 1'b0;
               err_d    = 1'b1;
            end
         end
         S_DONE, S_ERR: begin
            state_d = state_q;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (bus.start) begin
         state_d    = S_LOAD;
         byte_cnt_d = '0;
         bit_cnt_d  = 4'd0;
         sh_d       = 8'h00;
         csum_d     = 8'h00;
         chk_d      = 8'h00;
         pal_en_d   = 1'b0;
         err_d      = 1'b0;
         done_d     = 1'b0;
      end else begin
         chk_d = chk_d;
      end

      cfg_shift_d = (bit_cnt_d != 4'd0);
      cfg_bit_d   = sh_d[7];
      busy_d      = (state_d == S_LOAD) || (state_d == S_CHECK);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         state_q     <= S_IDLE;
         byte_cnt_q  <= '0;
         bit_cnt_q   <= 4'd0;
         sh_q        <= 8'h00;
         csum_q      <= 8'h00;
         chk_q       <= 8'h00;
         cfg_bit_q   <= 1'b0;
         cfg_shift_q <= 1'b0;
         pal_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         sh_q        <= sh_d;
         csum_q      <= csum_d;
         chk_q       <= chk_d;
         cfg_bit_q   <= cfg_bit_d;
         cfg_shift_q <= cfg_shift_d;
         pal_en_q    <= pal_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.din_ready = din_ready_s;
   assign bus.cfg_bit   = cfg_bit_q;
   assign bus.cfg_shift = cfg_shift_q;
   assign bus.pal_en    = pal_en_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule
